// File: rtl/io_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_controller : stalls the control unit for a debounced user IN, latches OUT
// Revision 1.0
// ----------------------------------------------------------------------------
module io_controller #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        inReq_i,
  input  logic        outReq_i,
  input  logic [31:0] regData_i,
  input  logic [15:0] switches_i,
  input  logic        button_i,
  output logic        interruption_o,
  output logic [31:0] dataIn_o,
  output logic [31:0] display_o,
  output logic        displayValid_o,
  output logic        ledWait_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_WAIT_RELEASE = 2'd2,
    ST_COMMIT       = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      data_in_q, data_in_d;
  logic [31:0]      display_q, display_d;
  logic             valid_q, valid_d;
  logic             w_deb_rise, w_deb_fall;
  logic             w_stall;

  // Count consecutive disagreement; the final count cycle flips the level.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == c_CNT_MAX) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Edges are taken from the next debounced level so acceptance lands on the same edge.
  assign w_deb_rise = ~deb_q & deb_d;
  assign w_deb_fall = deb_q & ~deb_d;

  always_comb begin
    state_d   = state_q;
    data_in_d = data_in_q;
    display_d = display_q;
    valid_d   = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (inReq_i) begin
          state_d = ST_WAIT_PRESS;
        end else if (outReq_i) begin
          display_d = regData_i;
          valid_d   = 1'b1;
        end
      end
      ST_WAIT_PRESS: begin
        if (w_deb_rise) begin
          data_in_d = {16'h0000, switches_i};
          state_d   = ST_WAIT_RELEASE;
        end
      end
      ST_WAIT_RELEASE: begin
        if (w_deb_fall) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_stall = (state_q == ST_WAIT_PRESS) || (state_q == ST_WAIT_RELEASE);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      sync_q    <= 2'b00;
      deb_q     <= 1'b0;
      cnt_q     <= '0;
      data_in_q <= 32'h0;
      display_q <= 32'h0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], button_i};
      deb_q     <= deb_d;
      cnt_q     <= cnt_d;
      data_in_q <= data_in_d;
      display_q <= display_d;
      valid_q   <= valid_d;
    end
  end

  assign interruption_o = w_stall;
  assign ledWait_o      = w_stall;
  assign dataIn_o       = data_in_q;
  assign display_o      = display_q;
  assign displayValid_o = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_io_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_io_controller : randomized transaction bench with scoreboard for io_controller
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_io_controller;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_req = 1'b0;
  logic        out_req = 1'b0;
  logic [31:0] reg_data = 32'h0;
  logic [15:0] switches = 16'h0;
  logic        button = 1'b0;
  logic        interruption;
  logic [31:0] data_in;
  logic [31:0] display;
  logic        disp_valid;
  logic        led_wait;

  int          n_cmp = 0;
  int          n_fail = 0;
  bit          noise = 1'b0;
  logic [31:0] model_din = 32'h0;
  logic [31:0] cur_disp = 32'h0;
  logic [31:0] exp_din[$];
  logic [31:0] exp_disp[$];

  io_controller #(.DEBOUNCE_CYCLES(D)) dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .inReq_i        (in_req),
    .outReq_i       (out_req),
    .regData_i      (reg_data),
    .switches_i     (switches),
    .button_i       (button),
    .interruption_o (interruption),
    .dataIn_o       (data_in),
    .display_o      (display),
    .displayValid_o (disp_valid),
    .ledWait_o      (led_wait)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the edge; while a stall is open, outReq/regData toggle randomly.
  task automatic tick();
    @(posedge clk);
    #1;
    if (noise) begin
      out_req  = 1'($urandom_range(0, 1));
      reg_data = $urandom;
    end
  endtask

  function automatic logic [31:0] new_val(input logic [31:0] avoid);
    logic [31:0] v;
    v = $urandom;
    while (v == avoid) v = $urandom;
    return v;
  endfunction

  function automatic logic [15:0] new_sw(input logic [15:0] avoid);
    logic [15:0] v;
    v = 16'($urandom);
    while (v == avoid) v = 16'($urandom);
    return v;
  endfunction

  task automatic show(input logic [31:0] v);
    reg_data = v;
    out_req  = 1'b1;
    exp_disp.push_back(v);
    tick();
    out_req  = 1'b0;
    cur_disp = v;
  endtask

  // inReq wins over a simultaneous outReq, so the display must not move here.
  task automatic start_req();
    in_req   = 1'b1;
    out_req  = 1'b1;
    reg_data = new_val(cur_disp);
    tick();
    in_req  = 1'b0;
    out_req = 1'b0;
    check("stall_start", interruption, 1);
    check("led_start", led_wait, 1);
    noise = 1'b1;
  endtask

  task automatic press(input logic [15:0] sw, input int nb, input int plen);
    int n;
    switches = sw;
    for (int i = 0; i < nb; i++) begin
      n = (plen == 0) ? $urandom_range(1, D - 1) : plen;
      button = 1'b1;
      repeat (n) tick();
      button = 1'b0;
      n = $urandom_range(1, 3);
      repeat (n) tick();
    end
    repeat (3) tick();
    check("bounce_no_capture", data_in, model_din);
    check("waiting_led", led_wait, 1);
    exp_din.push_back({16'h0000, sw});
    button = 1'b1;
    repeat (D + 1) tick();
    check("accept_not_early", data_in, model_din);
    tick();
    check("accept_latency", data_in, {16'h0000, sw});
    model_din = {16'h0000, sw};
  endtask

  task automatic release_btn(input logic [15:0] late, input int nb);
    int n;
    bit done;
    n = $urandom_range(1, 4);
    repeat (n) tick();
    switches = late;
    tick();
    check("stall_held", interruption, 1);
    for (int i = 0; i < nb; i++) begin
      button = 1'b0;
      n = $urandom_range(1, D - 1);
      repeat (n) tick();
      button = 1'b1;
      n = $urandom_range(1, 2);
      repeat (n) tick();
    end
    button = 1'b0;
    repeat (D + 1) tick();
    check("release_not_early", interruption, 1);
    done = 1'b0;
    for (int i = 0; i < D + 10; i++) begin
      tick();
      if (!interruption) begin
        done = 1'b1;
        break;
      end
    end
    noise = 1'b0;
    // An OUT request presented during COMMIT must be ignored.
    out_req  = 1'b1;
    reg_data = new_val(cur_disp);
    if (!done) check("commit_timeout", 1, 0);
  endtask

  task automatic finish_txn(input bit b2b);
    in_req = b2b;
    tick();
    out_req = 1'b0;
    check("commit_one_cycle", interruption, 0);
    if (b2b) begin
      tick();
      in_req = 1'b0;
      check("b2b_restart", interruption, 1);
      noise = 1'b1;
    end
  endtask

  // Scoreboard monitor: a stall dropping marks COMMIT; any display movement must be expected.
  initial begin : monitor
    logic        p_int;
    logic [31:0] p_disp;
    bit          rst_d;
    p_int  = 1'b0;
    p_disp = 32'h0;
    rst_d  = 1'b1;
    forever begin
      @(negedge clk);
      if (!(rst || rst_d)) begin
        if (p_int && !interruption) begin
          if (exp_din.size() == 0) check("unexpected_commit", data_in, 32'hxxxx_xxxx);
          else check("commit_dataIn", data_in, exp_din.pop_front());
        end
        if (display !== p_disp) begin
          if (exp_disp.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_display: got %h, previous %h (t=%0t)", display, p_disp, $time);
          end else begin
            check("display", display, exp_disp.pop_front());
            check("display_valid", disp_valid, 1);
          end
        end
      end
      p_int  = interruption;
      p_disp = display;
      rst_d  = rst;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [15:0] sw;
    bit          b2b;
    bit          started;
    int          nshow;
    int          nb;

    rst = 1'b1;
    repeat (3) tick();
    check("rst_stall", interruption, 0);
    check("rst_led", led_wait, 0);
    check("rst_dataIn", data_in, 0);
    check("rst_display", display, 0);
    check("rst_valid", disp_valid, 0);
    rst = 1'b0;
    tick();

    show(32'h0000_00A5);
    check("out_display", display, 32'h0000_00A5);
    check("out_valid", disp_valid, 1);
    check("out_no_stall", interruption, 0);

    // Clean press, switch change before release, bouncing press with pulses one short of D.
    start_req(); press(16'h1234, 0, 0); release_btn(16'h1234, 0); finish_txn(1'b0);
    start_req(); press(16'h00FF, 0, 0); release_btn(16'hFFFF, 0); finish_txn(1'b0);
    start_req(); press(new_sw(16'h00FF), 3, D - 1); release_btn(16'h5A5A, 2); finish_txn(1'b1);
    press(new_sw(model_din[15:0]), 1, 0); release_btn(16'h0F0F, 0); finish_txn(1'b0);

    // Button already held when the request arrives.
    button = 1'b1;
    repeat (D + 4) tick();
    start_req();
    switches = new_sw(model_din[15:0]);
    repeat (8) tick();
    check("held_no_capture", data_in, model_din);
    button = 1'b0;
    repeat (D + 4) tick();
    check("held_release_no_commit", interruption, 1);
    press(new_sw(model_din[15:0]), 0, 0); release_btn(new_sw(0), 0); finish_txn(1'b0);

    // Reset in WAIT_RELEASE abandons the transaction, with an OUT request competing.
    start_req();
    press(new_sw(model_din[15:0]), 0, 0);
    repeat (2) tick();
    noise    = 1'b0;
    out_req  = 1'b1;
    reg_data = new_val(32'h0);
    rst      = 1'b1;
    tick();
    check("midrst_stall", interruption, 0);
    check("midrst_led", led_wait, 0);
    check("midrst_dataIn", data_in, 0);
    check("midrst_display", display, 0);
    check("midrst_valid", disp_valid, 0);
    void'(exp_din.pop_back());
    rst       = 1'b0;
    out_req   = 1'b0;
    button    = 1'b0;
    model_din = 32'h0;
    cur_disp  = 32'h0;
    repeat (D + 6) tick();
    check("no_commit_after_reset", interruption, 0);

    started = 1'b0;
    for (int t = 0; t < 15; t++) begin
      if (!started) begin
        nshow = $urandom_range(0, 2);
        for (int k = 0; k < nshow; k++) begin
          show(new_val(cur_disp));
          repeat ($urandom_range(0, 2)) tick();
        end
        start_req();
      end
      b2b = ($urandom_range(0, 2) == 0) && (t < 14);
      nb  = $urandom_range(0, 3);
      sw  = new_sw(model_din[15:0]);
      press(sw, nb, 0);
      release_btn(new_sw(sw), nb);
      finish_txn(b2b);
      started = b2b;
    end

    repeat (4) tick();
    check("din_queue_empty", exp_din.size(), 0);
    check("disp_queue_empty", exp_disp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/io_controller.md
IO_CONTROLLER -- requirements
Module: io_controller

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a button level change is accepted (minimum 1).
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 inReq  input  1  IN request from the control unit (its LED output).
REQ-005 outReq  input  1  output request from the control unit (its flagOUT output).
REQ-006 regData  input  32  register-file read value to be displayed.
REQ-007 switches  input  16  user data switches, asynchronous.
REQ-008 button  input  1  user confirm button, asynchronous, active-high.
REQ-009 interruption  output  1  stall to the control unit; 1 forces all control flags to 0.
REQ-010 dataIn  output  32  captured input word, zero-extended switches, to the register-file mux.
REQ-011 display  output  32  latched output value.
REQ-012 displayValid  output  1  1 once display has been loaded since reset.
REQ-013 ledWait  output  1  user prompt; equals 1 exactly while in WAIT_PRESS or WAIT_RELEASE.

Function
REQ-014 button SHALL pass a 2-flop synchronizer before any use; switches SHALL be captured only at press acceptance.
REQ-015 Debounce: the debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to equality SHALL clear the count.
REQ-016 FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE, COMMIT.
REQ-017 IDLE, inReq=1 -> WAIT_PRESS next cycle; interruption SHALL be 1 from that cycle onward.
REQ-018 IDLE, inReq=0, outReq=1 -> display <= regData, displayValid <= 1 on the same edge; no stall; the state SHALL remain IDLE.
REQ-019 WAIT_PRESS: on the cycle the debounced level rises 0->1, dataIn <= {16'b0, switches} -> WAIT_RELEASE.
REQ-020 A press already held (debounced 1) on WAIT_PRESS entry SHALL NOT count; a fresh debounced 0->1 edge SHALL be required.
REQ-021 WAIT_RELEASE: on the debounced 1->0 edge -> COMMIT; switch changes SHALL NOT alter dataIn.
REQ-022 COMMIT: interruption SHALL be 0 for exactly one cycle so the control unit re-issues IN and writes dataIn; then -> IDLE unconditionally.
REQ-023 In COMMIT, inReq/outReq SHALL be ignored; in IDLE the next cycle, a new inReq SHALL start a new transaction.
REQ-024 interruption SHALL be 1 exactly in WAIT_PRESS and WAIT_RELEASE; it SHALL be 0 in IDLE and COMMIT.
REQ-025 dataIn SHALL hold its value until the next press acceptance.
REQ-026 display SHALL change only per REQ-018; outReq during a stall SHALL have no effect.
REQ-027 Minimum stall latency: press edge to WAIT_RELEASE = 2 + DEBOUNCE_CYCLES cycles.

Reset
REQ-028 reset=1 at a clock edge SHALL force IDLE and interruption=0, ledWait=0, dataIn=0, display=0, displayValid=0, debounced level=0, debounce count=0, synchronizer flops=0.
REQ-029 Reset mid-transaction SHALL abandon it with no COMMIT pulse; reset SHALL take priority over all other inputs.

Verification
REQ-030 reset, then outReq=1, inReq=0, regData=32'h0000_00A5 for 1 cycle -> display=32'hA5, displayValid=1, interruption stays 0.
REQ-031 inReq=1, switches=16'h1234, clean press held 10 cycles then release -> interruption high until release accepted, dataIn=32'h0000_1234, one COMMIT cycle with interruption=0, then IDLE.
REQ-032 Press bouncing with 3-cycle pulses (DEBOUNCE_CYCLES=4) -> no acceptance; a stable 4-cycle hold is then accepted.
REQ-033 Switches 16'h00FF at press, changed to 16'hFFFF before release -> dataIn=32'h0000_00FF.
REQ-034 Button held when inReq arrives -> no capture until release then re-press; reset asserted in WAIT_RELEASE -> IDLE next cycle, all outputs 0.
REQ-035 Back-to-back IN requests (inReq=1 again in the cycle after COMMIT) -> second transaction enters WAIT_PRESS; first dataIn retained until second press.
